// File: rtl/hotel_room_scheduler_if.sv
// Desk-side bus for the hotel front-desk controller.
// The desk (master) drives requests and reads back grant and result.
interface hotel_room_scheduler_if;
    logic [1:0]  req;
    logic [1:0]  op;
    logic [7:0]  id;
    logic [1:0]  ac;
    logic [1:0]  wifi;
    logic [5:0]  days;
    logic [1:0]  grant;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [2:0]  room_idx;
    logic [15:0] bill;
    logic [6:0]  occupancy;

    modport master (
        output req, op, id, ac, wifi, days,
        input  grant, busy, done, status, room_idx, bill, occupancy
    );

    modport slave (
        input  req, op, id, ac, wifi, days,
        output grant, busy, done, status, room_idx, bill, occupancy
    );
endinterface

// File: rtl/hotel_room_scheduler.sv
// Two-desk front-desk controller: round-robin arbitration, room allocate/release,
// and bill accumulation by repeated addition of the nightly rate.
module hotel_room_scheduler #(
    parameter int unsigned NUM_ROOMS  = 7,
    parameter int unsigned RATE_STD   = 700,
    parameter int unsigned RATE_ECO   = 400,
    parameter int unsigned RATE_SUITE = 500,
    parameter int unsigned AC_COST    = 200,
    parameter int unsigned WIFI_COST  = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    hotel_room_scheduler_if.slave bus
);
    localparam int unsigned ID_W   = 4;
    localparam int unsigned DAYS_W = 3;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BILL_W = 16;

    typedef enum logic [1:0] {IDLE, LOOKUP, CALC, DONE} state_t;

    typedef struct packed {
        logic              op;
        logic [ID_W-1:0]   id;
        logic              ac;
        logic              wifi;
        logic [DAYS_W-1:0] days;
    } txn_t;

    state_t state, state_d;
    txn_t   txn, cap;
    logic   last_q, win, cap_en;

    logic [ID_W-1:0]   table_q [NUM_ROOMS];
    logic [NUM_ROOMS-1:0] occ;
    logic [1:0]        grant_q, grant_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic [1:0]        status_q, status_d;
    logic [IDX_W-1:0]  room_q, room_d;
    logic [BILL_W-1:0] bill_q, bill_d, rate_q, rate_d;
    logic [DAYS_W-1:0] cnt_q, cnt_d;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [ID_W-1:0]   wr_val;
    logic              hit, free_found, ci_ok;
    logic [IDX_W-1:0]  hit_idx, free_idx;

    function automatic logic [BILL_W-1:0] base_rate(input logic [IDX_W-1:0] r);
        if (r <= 3'd1)      return BILL_W'(RATE_STD);
        else if (r == 3'd6) return BILL_W'(RATE_SUITE);
        else                return BILL_W'(RATE_ECO);
    endfunction

    // Desk 1 wins when it is the only requester, or on contention when desk 0 went last.
    assign win = (bus.req == 2'b10) | ((bus.req == 2'b11) & ~last_q);

    always_comb begin
        cap.op   = bus.op[win];
        cap.id   = win ? bus.id[7:4]   : bus.id[3:0];
        cap.ac   = bus.ac[win];
        cap.wifi = bus.wifi[win];
        cap.days = win ? bus.days[5:3] : bus.days[2:0];
    end

    // Descending scan leaves the lowest matching / free index.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = IDX_W'(7);
        free_found = 1'b0;
        free_idx   = IDX_W'(7);
        for (int r = int'(NUM_ROOMS) - 1; r >= 0; r--) begin
            if (txn.id != '0 && table_q[r] == txn.id) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(r);
            end
            if (table_q[r] == '0) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(r);
            end
        end
    end

    assign ci_ok = ~txn.op & (txn.id != '0) & ~hit & free_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.req != '0) state_d = LOOKUP;
            LOOKUP:  state_d = ci_ok ? CALC : DONE;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d  = '0;
        cap_en   = 1'b0;
        status_d = status_q;
        room_d   = room_q;
        bill_d   = bill_q;
        rate_d   = rate_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_val   = '0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        case (state)
            IDLE: begin
                if (bus.req != '0) begin
                    cap_en  = 1'b1;
                    grant_d = win ? 2'b10 : 2'b01;
                end
            end
            LOOKUP: begin
                bill_d = '0;
                room_d = IDX_W'(7);
                if (!txn.op) begin
                    if (txn.id == '0 || hit) begin
                        status_d = 2'b11;
                    end else if (!free_found) begin
                        status_d = 2'b01;
                    end else begin
                        status_d = 2'b00;
                        room_d   = free_idx;
                        wr_en    = 1'b1;
                        wr_idx   = free_idx;
                        wr_val   = txn.id;
                        rate_d   = base_rate(free_idx)
                                 + (txn.ac   ? BILL_W'(AC_COST)   : '0)
                                 + (txn.wifi ? BILL_W'(WIFI_COST) : '0);
                        cnt_d    = txn.days;
                    end
                end else if (hit) begin
                    status_d = 2'b10;
                    room_d   = hit_idx;
                    wr_en    = 1'b1;
                    wr_idx   = hit_idx;
                end else begin
                    status_d = 2'b11;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    bill_d = bill_q + rate_q;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Result/datapath registers; last_q=1 means desk 1 went last so desk 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            status_q <= '0;
            room_q   <= IDX_W'(7);
            bill_q   <= '0;
            rate_q   <= '0;
            cnt_q    <= '0;
            txn      <= '0;
            last_q   <= 1'b1;
            occ      <= '0;
            for (int r = 0; r < int'(NUM_ROOMS); r++) table_q[r] <= '0;
        end else begin
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            status_q <= status_d;
            room_q   <= room_d;
            bill_q   <= bill_d;
            rate_q   <= rate_d;
            cnt_q    <= cnt_d;
            if (cap_en) begin
                txn    <= cap;
                last_q <= win;
            end
            if (wr_en) begin
                table_q[wr_idx] <= wr_val;
                occ[wr_idx]     <= (wr_val != '0);
            end
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.status    = status_q;
    assign bus.room_idx  = room_q;
    assign bus.bill      = bill_q;
    assign bus.occupancy = occ;
endmodule

// File: tb/tb_hotel_room_scheduler.sv
// Directed bench for hotel_room_scheduler: allocation, billing, arbitration,
// error/full cases and mid-transaction reset, checked with immediate assertions.
module tb_hotel_room_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    hotel_room_scheduler_if bus();

    hotel_room_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant == 2'b00 && n < 40);
    endtask

    // Counts cycles after the grant cycle until done; also counts stray grants.
    task automatic wait_done(output int n, output int stray);
        n = 0;
        stray = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.grant != 2'b00) stray++;
        end while (!bus.done && n < 40);
    endtask

    task automatic txn(input string tag, input int desk, input logic op_v,
                       input logic [3:0] id_v, input logic ac_v, input logic wifi_v,
                       input logic [2:0] days_v, input logic [1:0] exp_st,
                       input logic [2:0] exp_room, input logic [15:0] exp_bill,
                       input int exp_lat);
        int n, stray;
        bus.op[desk]          = op_v;
        bus.id[4*desk +: 4]   = id_v;
        bus.ac[desk]          = ac_v;
        bus.wifi[desk]        = wifi_v;
        bus.days[3*desk +: 3] = days_v;
        bus.req[desk]         = 1'b1;
        wait_grant(n);
        check({tag, "_grant"}, 32'(bus.grant), (desk == 0) ? 32'd1 : 32'd2);
        bus.req[desk] = 1'b0;
        wait_done(n, stray);
        check({tag, "_done"},    32'(bus.done),     32'd1);
        check({tag, "_latency"}, 32'(n),            32'(exp_lat));
        check({tag, "_status"},  32'(bus.status),   32'(exp_st));
        check({tag, "_room"},    32'(bus.room_idx), 32'(exp_room));
        check({tag, "_bill"},    32'(bus.bill),     32'(exp_bill));
    endtask

    initial begin
        int bills [7] = '{700, 700, 400, 400, 400, 400, 500};
        logic [1:0] cg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] cs [4] = '{2'b00, 2'b00, 2'b11, 2'b11};
        logic [2:0] cr [4] = '{3'd0, 3'd1, 3'd7, 3'd7};
        logic [15:0] cb [4] = '{16'd700, 16'd0, 16'd0, 16'd0};
        int n, stray, done_seen;

        bus.req = '0; bus.op = '0; bus.id = '0; bus.ac = '0; bus.wifi = '0; bus.days = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(bus.grant),     32'd0);
        check("rst_done",  32'(bus.done),      32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_status",32'(bus.status),    32'd0);
        check("rst_bill",  32'(bus.bill),      32'd0);
        check("rst_occ",   32'(bus.occupancy), 32'd0);
        check("rst_room",  32'(bus.room_idx),  32'd7);
        rst = 1'b0;
        @(negedge clk);

        txn("ci5", 0, 1'b0, 4'd5, 1'b1, 1'b1, 3'd3, 2'b00, 3'd0, 16'd3000, 5);
        check("ci5_occ", 32'(bus.occupancy), 32'h01);
        txn("co5", 1, 1'b1, 4'd5, 1'b0, 1'b0, 3'd0, 2'b10, 3'd0, 16'd0, 1);
        check("co5_occ", 32'(bus.occupancy), 32'h00);

        for (int i = 1; i <= 7; i++)
            txn($sformatf("fill%0d", i), i % 2, 1'b0, 4'(i), 1'b0, 1'b0, 3'd1,
                2'b00, 3'(i - 1), 16'(bills[i-1]), 3);
        check("fill_occ", 32'(bus.occupancy), 32'h7F);
        txn("full8", 0, 1'b0, 4'd8, 1'b0, 1'b0, 3'd1, 2'b01, 3'd7, 16'd0, 1);

        txn("co3", 1, 1'b1, 4'd3, 1'b0, 1'b0, 3'd0, 2'b10, 3'd2, 16'd0, 1);
        check("co3_occ", 32'(bus.occupancy), 32'h7B);
        txn("ci9", 0, 1'b0, 4'd9, 1'b0, 1'b0, 3'd1, 2'b00, 3'd2, 16'd400, 3);
        check("ci9_occ", 32'(bus.occupancy), 32'h7F);

        txn("err_id0",  0, 1'b0, 4'd0,  1'b0, 1'b0, 3'd2, 2'b11, 3'd7, 16'd0, 1);
        txn("err_dup",  1, 1'b0, 4'd9,  1'b1, 1'b0, 3'd2, 2'b11, 3'd7, 16'd0, 1);
        txn("err_abs",  0, 1'b1, 4'd12, 1'b0, 1'b0, 3'd0, 2'b11, 3'd7, 16'd0, 1);

        txn("co7",   1, 1'b1, 4'd7,  1'b0, 1'b0, 3'd0, 2'b10, 3'd6, 16'd0, 1);
        txn("days0", 0, 1'b0, 4'd10, 1'b0, 1'b1, 3'd0, 2'b00, 3'd6, 16'd0, 2);

        // Contention from a fresh reset: both desks hold req throughout.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.op = 2'b00; bus.ac = 2'b00; bus.wifi = 2'b00;
        bus.id = {4'd3, 4'd2};
        bus.days = {3'd0, 3'd1};
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(n);
            check($sformatf("rr%0d_grant", k), 32'(bus.grant), 32'(cg[k]));
            wait_done(n, stray);
            if (k == 3) bus.req = 2'b00;
            check($sformatf("rr%0d_done", k),    32'(bus.done),     32'd1);
            check($sformatf("rr%0d_overlap", k), 32'(stray),        32'd0);
            check($sformatf("rr%0d_status", k),  32'(bus.status),   32'(cs[k]));
            check($sformatf("rr%0d_room", k),    32'(bus.room_idx), 32'(cr[k]));
            check($sformatf("rr%0d_bill", k),    32'(bus.bill),     32'(cb[k]));
        end
        check("rr_occ", 32'(bus.occupancy), 32'h03);

        // Reset while accumulating the bill.
        bus.op[0] = 1'b0; bus.id[3:0] = 4'd13; bus.days[2:0] = 3'd5; bus.req[0] = 1'b1;
        wait_grant(n);
        check("abort_grant", 32'(bus.grant), 32'd1);
        bus.req[0] = 1'b0;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort_busy_calc", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_occ",  32'(bus.occupancy), 32'd0);
        check("abort_busy", 32'(bus.busy),      32'd0);
        check("abort_room", 32'(bus.room_idx),  32'd7);
        repeat (8) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        txn("post_rst", 0, 1'b0, 4'd14, 1'b0, 1'b0, 3'd1, 2'b00, 3'd0, 16'd700, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
